// File: rtl/sort_ctrl_pkg.sv
// ============================================================================
// sort_ctrl_pkg : state encodings shared by the sort_ctrl sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

package sort_ctrl_pkg;

   localparam logic [1:0] ST_LOAD = 2'd0;
   localparam logic [1:0] ST_SORT = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sort_ctrl_gt_unit.sv
// ============================================================================
// gt_unit : unsigned a > b, taken as the borrow out of the subtraction b - a
// Revision 1.0
// ============================================================================
`default_nettype none

module gt_unit #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         gt
);

   logic [N:0] borrow;

   assign borrow[0] = 1'b0;

   // Ripple borrow chain: only the final borrow is needed, so no difference bits are formed.
   generate
      for (genvar i = 0; i < N; i++) begin : g_borrow
         assign borrow[i+1] = (~b[i] & a[i]) | (~(b[i] ^ a[i]) & borrow[i]);
      end
   endgenerate

   assign gt = borrow[N];

endmodule

`default_nettype wire

// File: rtl/sort_ctrl.sv
// ============================================================================
// sort_ctrl : loads DEPTH words, bubble-sorts them ascending with one shared
//             comparator (early exit on a swap-free pass), then streams them out
// Revision 1.0
// ============================================================================
`default_nettype none

module sort_ctrl #(
   parameter int N     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         busy
);

   import sort_ctrl_pkg::*;

   localparam int             IW       = $clog2(DEPTH);
   localparam logic [IW-1:0]  IDX_ONE  = IW'(1);
   localparam logic [IW-1:0]  LAST_IDX = IW'(DEPTH - 1);
   localparam logic [IW-1:0]  J_MAX    = IW'(DEPTH - 2);

   logic [1:0]    state_q,  state_d;
   logic [IW-1:0] wr_idx_q, wr_idx_d;
   logic [IW-1:0] rd_idx_q, rd_idx_d;
   logic [IW-1:0] j_q,      j_d;
   logic [IW-1:0] pass_q,   pass_d;
   logic          swap_q,   swap_d;
   logic [N-1:0]  bank_q [DEPTH];
   logic [N-1:0]  bank_d [DEPTH];

   logic [IW-1:0] j_nxt;
   logic          gt;
   logic          last_j;

   assign j_nxt  = j_q + IDX_ONE;
   assign last_j = (j_q == (J_MAX - pass_q));

   gt_unit #(.N(N)) u_gt (
      .a  (bank_q[j_q]),
      .b  (bank_q[j_nxt]),
      .gt (gt)
   );

   assign in_ready  = (state_q == ST_LOAD);
   assign out_valid = (state_q == ST_OUT);
   assign busy      = (state_q == ST_SORT);
   assign out_data  = out_valid ? bank_q[rd_idx_q] : '0;

   always_comb begin
      state_d  = state_q;
      wr_idx_d = wr_idx_q;
      rd_idx_d = rd_idx_q;
      j_d      = j_q;
      pass_d   = pass_q;
      swap_d   = swap_q;
      bank_d   = bank_q;

      case (state_q)
         ST_LOAD: begin
            if (in_valid) begin
               bank_d[wr_idx_q] = in_data;
               if (wr_idx_q == LAST_IDX) begin
                  wr_idx_d = '0;
                  state_d  = ST_SORT;
               end else begin
                  wr_idx_d = wr_idx_q + IDX_ONE;
               end
            end
         end
         ST_SORT: begin
            if (gt) begin
               bank_d[j_q]   = bank_q[j_nxt];
               bank_d[j_nxt] = bank_q[j_q];
            end
            if (last_j) begin
               j_d    = '0;
               swap_d = 1'b0;
               // A swap in this very cycle still counts toward the pass being dirty.
               if (!(swap_q | gt) || (pass_q == J_MAX)) begin
                  state_d = ST_OUT;
                  pass_d  = '0;
               end else begin
                  pass_d = pass_q + IDX_ONE;
               end
            end else begin
               j_d    = j_nxt;
               swap_d = swap_q | gt;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               if (rd_idx_q == LAST_IDX) begin
                  rd_idx_d = '0;
                  pass_d   = '0;
                  j_d      = '0;
                  state_d  = ST_LOAD;
               end else begin
                  rd_idx_d = rd_idx_q + IDX_ONE;
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_LOAD;
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         j_q      <= '0;
         pass_q   <= '0;
         swap_q   <= 1'b0;
         bank_q   <= '{default: '0};
      end else begin
         state_q  <= state_d;
         wr_idx_q <= wr_idx_d;
         rd_idx_q <= rd_idx_d;
         j_q      <= j_d;
         pass_q   <= pass_d;
         swap_q   <= swap_d;
         bank_q   <= bank_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sort_ctrl.sv
// ============================================================================
// tb_sort_ctrl : table-driven self-checking bench for sort_ctrl (N=8, DEPTH=4)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sort_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       busy;

   always #5 clk = ~clk;

   sort_ctrl #(.N(8), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   typedef struct {
      logic [3:0][7:0] din;
      logic [3:0][7:0] dout;
      int              busy_cyc;
      bit              junk;
      int              stall;
   } vec_t;

   vec_t       vecs[6];
   logic [7:0] exp_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [7:0] a0, a1, a2, a3, e0, e1, e2, e3,
                               input int b, input bit j, input int s);
      vec_t v;
      v.din[0] = a0; v.din[1] = a1; v.din[2] = a2; v.din[3] = a3;
      v.dout[0] = e0; v.dout[1] = e1; v.dout[2] = e2; v.dout[3] = e3;
      v.busy_cyc = b;
      v.junk     = j;
      v.stall    = s;
      return v;
   endfunction

   // Drive one batch; the expected sorted word for each slot is queued as it is driven.
   task automatic load(input vec_t v);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = v.din[i];
         exp_q.push_back(v.dout[i]);
         check("in_ready_during_load", in_ready, 1);
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(input int stall);
      int got        = 0;
      int budget     = 0;
      int stall_left = stall;
      while (got < 4 && budget < 200) begin
         out_ready = !(got == 2 && stall_left > 0);
         if (!out_ready) stall_left--;
         if (out_valid) begin
            if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
            else                  check("unexpected_output", 1, 0);
            if (out_ready) begin
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               got++;
            end
         end else begin
            check("out_data_idle_zero", out_data, 0);
         end
         step();
         budget++;
      end
      out_ready = 1'b1;
      if (got < 4) check("drain_timeout_words", got, 4);
      check("in_ready_after_out", in_ready, 1);
      check("out_valid_after_out", out_valid, 0);
   endtask

   task automatic run_batch(input vec_t v);
      int cnt = 0;
      load(v);
      if (v.junk) begin
         in_valid = 1'b1;
         in_data  = 8'hEE;
      end
      while (busy && cnt < 100) begin
         cnt++;
         step();
      end
      check("busy_cycles", cnt, v.busy_cyc);
      drain(v.stall);
      in_valid = 1'b0;
   endtask

   initial begin
      vecs[0] = mk(8'd4, 8'd3, 8'd2, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 6, 1'b0, 0);
      vecs[1] = mk(8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4, 3, 1'b0, 0);
      vecs[2] = mk(8'h80, 8'h7F, 8'hFF, 8'h00, 8'h00, 8'h7F, 8'h80, 8'hFF, 6, 1'b0, 0);
      vecs[3] = mk(8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 3, 1'b1, 0);
      vecs[4] = mk(8'd9, 8'd1, 8'd7, 8'd3, 8'd1, 8'd3, 8'd7, 8'd9, 6, 1'b0, 3);
      vecs[5] = mk(8'd2, 8'd0, 8'd1, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 5, 1'b0, 0);

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_busy", busy, 0);

      for (int k = 0; k < 5; k++) run_batch(vecs[k]);

      // Reset during the second SORT cycle discards the batch.
      load(vecs[0]);
      check("busy_sort_cycle1", busy, 1);
      step();
      check("busy_sort_cycle2", busy, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
      check("midsort_rst_in_ready", in_ready, 1);
      check("midsort_rst_out_valid", out_valid, 0);
      check("midsort_rst_busy", busy, 0);
      check("midsort_rst_out_data", out_data, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("no_partial_output", out_valid, 0);
      end
      run_batch(vecs[5]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
